// File: rtl/FIR_pkg.sv
// Shared types and helpers for the multi-cycle-adder FIR estimator front end.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package FIR_pkg;

  // Sequencer states: FILL until the lookback window is full, RUN waiting for
  // the next decimation point, BUSY while the adder tree result is pending.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    RUN  = 2'd1,
    BUSY = 2'd2
  } seq_state_e;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/s_lookback_shift_reg.sv
// K-bit lookback window of L = K/N rows of N control bits, newest row in bits [N-1:0].
// Latency: window_next is combinational (history plus the incoming sample); history updates on the en edge.
// Backpressure: none; en=0 simply holds the history.
module s_lookback_shift_reg #(
  parameter int N = 8,
  parameter int K = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] s_in,
  output logic [K-1:0] window_next
);

  localparam int L = K / N;

  // Snapshots are always taken from the post-shift view, so the oldest row of
  // the stored window would be shifted out before anyone could read it. Only
  // the newest L-1 rows are kept; window_next rebuilds the full L-row window.
  generate
    if (L > 1) begin : g_multi_row
      logic [K-N-1:0] hist;

      assign window_next = {hist, s_in};

      // Shift one row older on every accepted sample, hold otherwise.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hist <= '0;
        end else if (en) begin
          hist <= window_next[K-N-1:0];
        end
      end
    end else begin : g_single_row
      assign window_next = s_in;
    end
  endgenerate

endmodule

// File: rtl/mca_input_sequencer.sv
// Lookback window, OSR decimation and result capture in front of the multi-cycle adder tree.
// Latency: start one cycle after the decimating sample edge; result captured MCA_LATENCY+1 edges after that.
// Backpressure: none; a decimation point arriving while busy is dropped and flagged in sticky overrun.
module mca_input_sequencer
  import FIR_pkg::*;
#(
  parameter int K                 = 256,
  parameter int N                 = 8,
  parameter int OSR               = 16,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int MCA_LATENCY       = 48
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic        [N-1:0]                 s_in,
  input  logic                                s_valid,
  output logic                                S_matrix [K-1:0],
  output logic                                start,
  input  logic signed [WIDTH_COEFFICIENT-1:0] sample_in,
  output logic signed [WIDTH_COEFFICIENT-1:0] sample_out,
  output logic                                sample_valid,
  output logic                                busy,
  output logic                                overrun
);

  localparam int L  = K / N;
  localparam int FW = cnt_width(L);
  localparam int DW = cnt_width(OSR - 1);
  localparam int LW = cnt_width(MCA_LATENCY);

  localparam logic [FW-1:0] FILL_LAST = FW'(L - 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(L);
  localparam logic [DW-1:0] DEC_LAST  = DW'(OSR - 1);
  localparam logic [LW-1:0] LAT_LOAD  = LW'(MCA_LATENCY);

  seq_state_e     state_q, state_d;
  logic [FW-1:0]  fill_cnt;
  logic [DW-1:0]  dec_cnt;
  logic [LW-1:0]  lat_cnt;
  logic [K-1:0]   window_next;
  logic           dec_point;
  logic           capture;
  logic           take_snap;
  logic           miss;

  s_lookback_shift_reg #(
    .N (N),
    .K (K)
  ) u_lookback (
    .clk         (clk),
    .reset       (reset),
    .en          (s_valid),
    .s_in        (s_in),
    .window_next (window_next)
  );

  // Next state, decimation/capture decode and snapshot/overrun decisions.
  always_comb begin
    state_d   = state_q;
    dec_point = 1'b0;
    capture   = 1'b0;
    take_snap = 1'b0;
    miss      = 1'b0;
    case (state_q)
      FILL: begin
        dec_point = s_valid && (fill_cnt == FILL_LAST);
        if (dec_point) begin
          take_snap = 1'b1;
          state_d   = BUSY;
        end
      end
      RUN: begin
        dec_point = s_valid && (dec_cnt == DEC_LAST);
        if (dec_point) begin
          take_snap = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        dec_point = s_valid && (dec_cnt == DEC_LAST);
        capture   = (lat_cnt == '0);
        if (capture) begin
          // A result landing on the same edge as a decimation point frees
          // the tree in time, so the new snapshot is accepted back to back.
          if (dec_point) begin
            take_snap = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else if (dec_point) begin
          miss = 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Count valid samples until the window first holds L rows.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_cnt <= '0;
    end else if ((state_q == FILL) && s_valid && (fill_cnt != FILL_FULL)) begin
      fill_cnt <= fill_cnt + FW'(1);
    end
  end

  // Decimation phase: held at 0 while filling, then wraps every OSR valid samples
  // regardless of whether the decimation point was accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_cnt <= '0;
    end else if (state_q == FILL) begin
      dec_cnt <= '0;
    end else if (s_valid) begin
      dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + DW'(1);
    end
  end

  // Adder tree latency countdown; reaching 0 in BUSY marks the capture edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (take_snap) begin
      lat_cnt <= LAT_LOAD;
    end else if ((state_q == BUSY) && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - LW'(1);
    end
  end

  // Freeze the post-shift window as the adder tree operand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < K; i++) S_matrix[i] <= 1'b0;
    end else if (take_snap) begin
      for (int i = 0; i < K; i++) S_matrix[i] <= window_next[i];
    end
  end

  // Start pulse, captured result, its valid pulse and the sticky overrun flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start        <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      start        <= take_snap;
      sample_valid <= capture;
      overrun      <= overrun | miss;
      if (capture) begin
        sample_out <= sample_in;
      end
    end
  end

  assign busy = (state_q == BUSY);

endmodule
